spi_secondary: RTL and testbench

//   SPI secondary (responder) endpoint for the other end of the link driven by spi_core.

---
 rtl/spi_secondary.sv | 191 +++++++++++++++++++
 tb/tb_spi_secondary.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_secondary.sv
// SPI secondary endpoint: oversampled sclk/cs/mosi, MSB-first, MOSI captured on
// rising sclk, MISO launched on falling sclk. Parallel TX holding buffer and RX
// data/valid handshake toward local logic. Single clock domain (clk).
module spi_secondary #(
    parameter int unsigned DWIDTH      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic              miso,
    input  logic [DWIDTH-1:0] tx_data,
    input  logic              tx_wr,
    output logic              tx_ready,
    output logic [DWIDTH-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ack,
    output logic              busy,
    output logic              underrun,
    output logic              overrun
);

    localparam int unsigned CW = (DWIDTH > 2) ? $clog2(DWIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DWIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;
    logic                   r_cs_d;

    state_t                 r_state;
    logic [CW-1:0]          r_bitcnt;
    logic [DWIDTH-1:0]      r_tx_buf;
    logic                   r_tx_empty;
    logic [DWIDTH-2:0]      r_tx_shreg;
    logic [DWIDTH-2:0]      r_rx_shift;
    logic [DWIDTH-1:0]      r_rx_data;
    logic                   r_rx_valid;
    logic                   r_miso;
    logic                   r_busy;
    logic                   r_underrun;
    logic                   r_overrun;

    logic                   w_sclk_s;
    logic                   w_cs_s;
    logic                   w_mosi_s;
    logic                   w_sclk_rise;
    logic                   w_sclk_fall;
    logic                   w_cs_rise;
    logic                   w_cs_fall;
    logic                   w_consume;
    logic [DWIDTH-1:0]      w_tx_word;
    logic [DWIDTH-1:0]      w_rx_word;

    // Synchronise the asynchronous SPI pins and keep one delayed copy for edges.
    // cs resets to 0 so a cs already low at reset release does not look like a
    // falling edge; a fresh deassert/assert is needed to start a frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '0;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_sclk_d    <= w_sclk_s;
            r_cs_d      <= w_cs_s;
        end
    end

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
    assign w_cs_rise   = w_cs_s & ~r_cs_d;
    assign w_cs_fall   = ~w_cs_s & r_cs_d;

    // Word launched at frame start: the buffer if full, otherwise all zero.
    assign w_tx_word = r_tx_empty ? '0 : r_tx_buf;
    assign w_rx_word = {r_rx_shift, w_mosi_s};

    // Buffer is consumed on LOAD and on the falling edge at a frame boundary.
    assign w_consume = ~w_cs_rise &
                       ((r_state == ST_LOAD) |
                        ((r_state == ST_SHIFT) & w_sclk_fall & (r_bitcnt == '0)));

    // Frame FSM, TX holding buffer and RX handshake; cs deassert overrides all.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_bitcnt   <= '0;
            r_tx_buf   <= '0;
            r_tx_empty <= 1'b1;
            r_tx_shreg <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_miso     <= 1'b0;
            r_busy     <= 1'b0;
            r_underrun <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            r_overrun  <= 1'b0;

            if (w_consume) begin
                r_tx_empty <= 1'b1;
                r_underrun <= r_tx_empty;
            end else if (tx_wr && r_tx_empty) begin
                r_tx_buf   <= tx_data;
                r_tx_empty <= 1'b0;
            end

            if (rx_ack) begin
                r_rx_valid <= 1'b0;
            end

            if (w_cs_rise) begin
                r_state  <= ST_IDLE;
                r_miso   <= 1'b0;
                r_bitcnt <= '0;
                r_busy   <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_miso <= 1'b0;
                        if (w_cs_fall) begin
                            r_state <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        r_tx_shreg <= w_tx_word[DWIDTH-2:0];
                        r_miso     <= w_tx_word[DWIDTH-1];
                        r_bitcnt   <= '0;
                        r_busy     <= 1'b0;
                        r_state    <= ST_SHIFT;
                    end
                    ST_SHIFT: begin
                        if (w_sclk_rise) begin
                            r_rx_shift <= w_rx_word[DWIDTH-2:0];
                            if (r_bitcnt == LAST_BIT) begin
                                r_rx_data  <= w_rx_word;
                                r_rx_valid <= 1'b1;
                                r_overrun  <= r_rx_valid & ~rx_ack;
                                r_bitcnt   <= '0;
                                r_busy     <= 1'b0;
                            end else begin
                                r_bitcnt <= r_bitcnt + CW'(1);
                                r_busy   <= 1'b1;
                            end
                        end else if (w_sclk_fall) begin
                            if (r_bitcnt != '0) begin
                                r_miso     <= r_tx_shreg[DWIDTH-2];
                                r_tx_shreg <= r_tx_shreg << 1;
                            end else begin
                                r_tx_shreg <= w_tx_word[DWIDTH-2:0];
                                r_miso     <= w_tx_word[DWIDTH-1];
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_miso  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign miso     = r_miso;
    assign tx_ready = r_tx_empty;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign busy     = r_busy;
    assign underrun = r_underrun;
    assign overrun  = r_overrun;

endmodule

// File: tb/tb_spi_secondary.sv
// Directed bench for spi_secondary: the bench plays the SPI initiator
// (mode 0, sclk = clk/8) and checks the parallel side against hand values.
module tb_spi_secondary;

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk;
    logic       cs;
    logic       mosi;
    logic       miso;
    logic [7:0] tx_data;
    logic       tx_wr;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       busy;
    logic       underrun;
    logic       overrun;

    int errors = 0;
    int checks = 0;
    int n_under = 0;
    int n_over = 0;
    int u0;
    int o0;
    logic [7:0] got;
    logic [7:0] got2;

    spi_secondary #(.DWIDTH(8), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .sclk     (sclk),
        .cs       (cs),
        .mosi     (mosi),
        .miso     (miso),
        .tx_data  (tx_data),
        .tx_wr    (tx_wr),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ack   (rx_ack),
        .busy     (busy),
        .underrun (underrun),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    // Pulse counters for the single-cycle status outputs.
    always @(posedge clk) begin
        if (underrun) n_under <= n_under + 1;
        if (overrun)  n_over  <= n_over + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_wr(input logic [7:0] d);
        tx_data = d;
        tx_wr   = 1'b1;
        @(negedge clk);
        tx_wr   = 1'b0;
    endtask

    task automatic pulse_ack();
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
    endtask

    // Initiator: nbits MSB-first bits, 4 clk per sclk phase. Optional tx_wr and
    // rx_ack pulses during bit 3. With end_cs, cs rises together with the last
    // sclk fall, then the bench idles 5 clk.
    task automatic spi_frame(input logic [7:0] tx, input int nbits, input bit end_cs,
                             input bit do_wr, input logic [7:0] wr_data, input bit do_ack,
                             output logic [7:0] rx);
        if (cs) begin
            cs = 1'b0;
            repeat (8) @(negedge clk);
        end
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            repeat (2) @(negedge clk);
            if (i == 3) begin
                tx_data = wr_data;
                tx_wr   = do_wr;
                rx_ack  = do_ack;
            end
            @(negedge clk);
            tx_wr  = 1'b0;
            rx_ack = 1'b0;
            @(negedge clk);
            rx   = {rx[6:0], miso};
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
            if (end_cs && i == nbits - 1) cs = 1'b1;
        end
        if (end_cs) repeat (5) @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; sclk = 1'b0; cs = 1'b1; mosi = 1'b0;
        tx_data = '0; tx_wr = 1'b0; rx_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_miso",     32'(miso),     32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_rx_data",  32'(rx_data),  32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_overrun",  32'(overrun),  32'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // Single frame; second write while buffer full must be ignored.
        u0 = n_under; o0 = n_over;
        pulse_wr(8'h3C);
        check("wr_tx_ready", 32'(tx_ready), 32'd0);
        pulse_wr(8'h99);
        spi_frame(8'hA5, 8, 1'b1, 1'b0, 8'h00, 1'b0, got);
        check("single_miso",     32'(got),          32'h3C);
        check("single_rx_data",  32'(rx_data),      32'hA5);
        check("single_rx_valid", 32'(rx_valid),     32'd1);
        check("single_tx_ready", 32'(tx_ready),     32'd1);
        check("single_underrun", 32'(n_under - u0), 32'd0);
        check("single_miso_idle", 32'(miso),        32'd0);
        pulse_ack();
        check("ack_rx_valid", 32'(rx_valid), 32'd0);

        // Back-to-back frames with cs held low.
        u0 = n_under; o0 = n_over;
        pulse_wr(8'h81);
        spi_frame(8'h12, 8, 1'b0, 1'b1, 8'h7E, 1'b0, got);
        check("b2b_miso1",     32'(got),      32'h81);
        check("b2b_rx_data1",  32'(rx_data),  32'h12);
        check("b2b_rx_valid1", 32'(rx_valid), 32'd1);
        spi_frame(8'h34, 8, 1'b1, 1'b0, 8'h00, 1'b1, got2);
        check("b2b_miso2",     32'(got2),         32'h7E);
        check("b2b_rx_data2",  32'(rx_data),      32'h34);
        check("b2b_underrun",  32'(n_under - u0), 32'd0);
        check("b2b_overrun",   32'(n_over - o0),  32'd0);
        pulse_ack();

        // Underrun and overrun: empty buffer, two frames, no ack.
        u0 = n_under; o0 = n_over;
        spi_frame(8'hFF, 8, 1'b0, 1'b0, 8'h00, 1'b0, got);
        check("uo_miso1",    32'(got),     32'h00);
        check("uo_rx_data1", 32'(rx_data), 32'hFF);
        spi_frame(8'h00, 8, 1'b1, 1'b0, 8'h00, 1'b0, got2);
        check("uo_miso2",    32'(got2),         32'h00);
        check("uo_underrun", 32'(n_under - u0), 32'd2);
        check("uo_overrun",  32'(n_over - o0),  32'd1);
        check("uo_rx_data2", 32'(rx_data),      32'h00);
        pulse_ack();

        // Abort after 5 bits of C3, then a full frame 5A.
        spi_frame(8'hC3, 5, 1'b0, 1'b0, 8'h00, 1'b0, got);
        check("abort_busy_mid", 32'(busy), 32'd1);
        cs = 1'b1;
        repeat (6) @(negedge clk);
        check("abort_busy",     32'(busy),     32'd0);
        check("abort_rx_valid", 32'(rx_valid), 32'd0);
        spi_frame(8'h5A, 8, 1'b1, 1'b0, 8'h00, 1'b0, got);
        check("abort_next_rx_data",  32'(rx_data),  32'h5A);
        check("abort_next_rx_valid", 32'(rx_valid), 32'd1);
        pulse_ack();

        // Exchange: secondary sends 55, initiator sends AA.
        pulse_wr(8'h55);
        spi_frame(8'hAA, 8, 1'b1, 1'b0, 8'h00, 1'b0, got);
        check("xchg_miso",    32'(got),     32'h55);
        check("xchg_rx_data", 32'(rx_data), 32'hAA);

        // Reset mid-frame with rx_valid set and TX buffer full.
        pulse_wr(8'h11);
        check("pre_rst_tx_ready", 32'(tx_ready), 32'd0);
        spi_frame(8'hFF, 3, 1'b0, 1'b0, 8'h00, 1'b0, got);
        rst = 1'b0;
        #1;
        check("mid_rst_miso",     32'(miso),     32'd0);
        check("mid_rst_tx_ready", 32'(tx_ready), 32'd1);
        check("mid_rst_rx_data",  32'(rx_data),  32'd0);
        check("mid_rst_rx_valid", 32'(rx_valid), 32'd0);
        check("mid_rst_busy",     32'(busy),     32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        // cs still low: clocking must not start a frame.
        spi_frame(8'hF0, 8, 1'b0, 1'b0, 8'h00, 1'b0, got);
        repeat (5) @(negedge clk);
        check("held_cs_rx_valid", 32'(rx_valid), 32'd0);
        check("held_cs_busy",     32'(busy),     32'd0);
        check("held_cs_miso",     32'(got),      32'h00);
        cs = 1'b1;
        repeat (6) @(negedge clk);
        spi_frame(8'h96, 8, 1'b1, 1'b0, 8'h00, 1'b0, got);
        check("post_rst_rx_data",  32'(rx_data),  32'h96);
        check("post_rst_rx_valid", 32'(rx_valid), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
